wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port among three write-back requesters: 0 = ALU, 1 = LSU, 2 = CSR. It uses round-robin arbitration with valid/ready handshakes and drives a registered write port. It also tracks pending destination registers so that decode can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register-file write port.

## Interface
- XLEN, 64, data width of a register (matches the register bus width)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; all state cleared while low
- iss_valid  in  1  decode is issuing an instruction that writes iss_rd
- iss_rd  in  5  destination register of the issuing instruction
- iss_ready  out  1  issue accepted this cycle; low if iss_rd is pending
- req_valid  in  3  per-requester write-back request
- req_addr  in  15  packed destination addresses, requester i at [5i+4:5i]
- req_data  in  3*XLEN  packed write data, requester i at [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  3  per-requester grant, at most one bit set
- w_ena  out  1  register-file write enable
- w_addr  out  5  register-file write address
- w_data  out  XLEN  register-file write data
- rs1_addr, rs2_addr  in  5 each  decode source addresses
- rs1_busy, rs2_busy  out  1 each  source register has a pending write
- busy_o  out  32  scoreboard bit vector, for debug and difftest

## Operation
- Scoreboard:
  - 32 busy bits; bit 0 is hard-wired 0.
  - `iss_ready = !busy[iss_rd]`, combinational. iss_rd = 0 is always ready.
  - An issue fires when iss_valid && iss_ready. It sets busy[iss_rd] at the next edge, except when iss_rd = 0.
  - busy[w_addr] clears at the edge on which w_ena is high. That is the same edge on which the register file commits the write.
  - Same-register set and clear on one edge: the set wins.
  - `rsN_busy = busy[rsN_addr]`, combinational. Address 0 always reads 0.
- Arbiter:
  - A 2-bit round-robin pointer `prio` (values 0..2) names the highest-priority requester.
  - Candidates are scanned prio, prio+1, prio+2 (mod 3). The first one with req_valid set gets req_ready, combinationally.
  - After a grant to requester i, prio becomes (i+1) mod 3. With no grant, prio holds.
  - A handshake is req_valid[i] && req_ready[i]. The requester holds valid, addr and data stable until it is granted.
  - There is no backpressure from the register file: a grant is given whenever any request is valid.
  - A write to address 0 is granted and forwarded with w_addr = 0. The register file drops it, and busy is unaffected.
  - A write to a non-busy register is forwarded unchanged.
- Output register:
  - The granted address and data are captured into w_addr/w_data.
  - w_ena is set for exactly one cycle per handshake.

## Timing
- Reset values:
  - w_ena = 0, w_addr = 0, w_data = 0
  - busy = 0, prio = 0
  - Combinational outputs follow from this state: iss_ready = 1, rsN_busy = 0, req_ready follows req_valid.
- Reset mid-operation:
  - Asserting rst clears all state immediately, independent of clk.
  - An in-flight w_ena drops within the same cycle, and the pending write is lost.
- Write latency:
  - Handshake in cycle N gives w_ena = 1 in cycle N+1.
  - The register file is updated at the end of N+1, and the busy bit clears at that same edge.
  - A dependent instruction sees rsN_busy = 0 and reads correct data in cycle N+2.
- Throughput is one write-back per cycle. With all three requesters continuously valid, grants rotate 0,1,2,0,…
- Issue to set: an issue in cycle N makes busy visible in cycle N+1.

## Test plan
- Reset: hold rst low with random inputs -> w_ena = 0, busy_o = 0, iss_ready = 1. Release rst -> first grant with all req_valid = 3'b111 goes to requester 0.
- Round-robin: req_valid = 3'b111 held for 6 cycles with addrs 1,2,3 -> req_ready sequence 001,010,100,001,010,100. w_addr sequence 1,2,3,1,2,3, each one cycle after its grant.
- Scoreboard RAW:
  - Issue rd = 5 in cycle 0 -> rs1_busy = 1 for rs1_addr = 5 from cycle 1.
  - LSU writes x5 = 0xDEADBEEF, granted in cycle 3 -> w_ena = 1 in cycle 4, rs1_busy = 0 in cycle 5.
- WAW stall: with busy[7] = 1, iss_valid with iss_rd = 7 -> iss_ready = 0 until busy[7] clears. Then iss_ready = 1 and busy[7] is set again.
- Set/clear collision: w_ena = 1 with w_addr = 9 in the same cycle as an issue with iss_rd = 9 (busy[9] cleared by that write) -> busy[9] = 1 next cycle.
- x0 handling:
  - Issue rd = 0 -> iss_ready = 1 and busy_o stays 0.
  - ALU write to addr 0 -> granted, w_ena = 1 with w_addr = 0, and busy_o is unchanged.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle: issue port, three packed write-back requesters,
// register-file write port, source-operand busy lookup and scoreboard debug vector.
interface wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic                 iss_valid;
    logic [4:0]           iss_rd;
    logic                 iss_ready;

    logic [2:0]           req_valid;
    logic [14:0]          req_addr;
    logic [3*XLEN-1:0]    req_data;
    logic [2:0]           req_ready;

    logic                 w_ena;
    logic [4:0]           w_addr;
    logic [XLEN-1:0]      w_data;

    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [31:0]          busy_o;

    // The arbiter itself.
    modport slave (
        input  iss_valid, iss_rd, req_valid, req_addr, req_data, rs1_addr, rs2_addr,
        output iss_ready, req_ready, w_ena, w_addr, w_data, rs1_busy, rs2_busy, busy_o
    );

    // Decode, the execute/memory requesters and the register file.
    modport master (
        output iss_valid, iss_rd, req_valid, req_addr, req_data, rs1_addr, rs2_addr,
        input  iss_ready, req_ready, w_ena, w_addr, w_data, rs1_busy, rs2_busy, busy_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter (ALU, LSU, CSR) onto a registered register-file
// write port, plus a 32-entry pending-destination scoreboard for RAW/WAW stalls.
module wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        PRIO_ALU = 2'd0,
        PRIO_LSU = 2'd1,
        PRIO_CSR = 2'd2
    } prio_e;

    prio_e             prio_q, prio_d;
    logic [31:0]       busy_q, busy_d;
    logic              w_ena_q;
    logic [4:0]        w_addr_q;
    logic [XLEN-1:0]   w_data_q;

    logic [1:0]        cand;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic [2:0]        grant;
    logic [4:0]        gnt_addr;
    logic [XLEN-1:0]   gnt_data;
    logic              iss_ready;
    logic              issue_fire;

    // (base + off) mod 3 for base, off in 0..2.
    function automatic logic [1:0] rr_cand(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        cand    = 2'd0;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = rr_cand(prio_q, 2'(k));
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        grant = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    end

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                gnt_addr = gnt_addr | bus.req_addr[5*i +: 5];
                gnt_data = gnt_data | bus.req_data[XLEN*i +: XLEN];
            end
        end
    end

    assign iss_ready  = !busy_q[bus.iss_rd];
    assign issue_fire = bus.iss_valid && iss_ready;

    // The clear from the committing write is applied first so a same-register issue wins.
    always_comb begin
        busy_d = busy_q;
        if (w_ena_q) begin
            busy_d[w_addr_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign prio_d = gnt_any ? prio_e'(rr_cand(gnt_idx, 2'd1)) : prio_q;

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q   <= PRIO_ALU;
            busy_q   <= '0;
            w_ena_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            prio_q  <= prio_d;
            busy_q  <= busy_d;
            w_ena_q <= gnt_any;
            if (gnt_any) begin
                w_addr_q <= gnt_addr;
                w_data_q <= gnt_data;
            end
        end
    end

    assign bus.iss_ready = iss_ready;
    assign bus.req_ready = grant;
    assign bus.w_ena     = w_ena_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.rs1_busy  = busy_q[bus.rs1_addr];
    assign bus.rs2_busy  = busy_q[bus.rs2_addr];
    assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, with a queue-based
// scoreboard fed by a set-based reference model and drained by a negedge monitor.
module tb_wb_arbiter;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_arbiter #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic            ena;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Reference model: set of pending destinations, priority pointer, write on the port.
    bit [31:0] m_busy;
    int        m_prio;
    bit        m_pend_ena;
    int        m_pend_addr;
    int        last_grant;

    logic [2:0]  exp_req_ready;
    logic        exp_iss_ready, exp_rs1, exp_rs2;
    logic [31:0] exp_busy;

    bit              r_valid [3];
    logic [4:0]      r_addr  [3];
    logic [XLEN-1:0] r_data  [3];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wq_empty: got w_ena=%0b with no expected entry at %0t", bus.w_ena, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("w_ena", 64'(bus.w_ena), 64'(e.ena));
                if (e.ena) begin
                    check("w_addr", 64'(bus.w_addr), 64'(e.addr));
                    check("w_data", bus.w_data, e.data);
                end
            end
            check("req_ready", 64'(bus.req_ready), 64'(exp_req_ready));
            check("iss_ready", 64'(bus.iss_ready), 64'(exp_iss_ready));
            check("rs1_busy",  64'(bus.rs1_busy),  64'(exp_rs1));
            check("rs2_busy",  64'(bus.rs2_busy),  64'(exp_rs2));
            check("busy_o",    64'(bus.busy_o),    64'(exp_busy));
        end
    end

    // Evaluate the model on the inputs currently driven, queue the write this cycle
    // produces, advance the model across the next edge, and move to just after it.
    task automatic tick();
        int  g;
        wr_t e;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_prio + k) % 3;
            if (g < 0 && bus.req_valid[c]) g = c;
        end
        exp_req_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        exp_iss_ready = (bus.iss_rd == 5'd0) || !m_busy[bus.iss_rd];
        exp_rs1       = m_busy[bus.rs1_addr];
        exp_rs2       = m_busy[bus.rs2_addr];
        exp_busy      = m_busy;
        e = '0;
        if (g >= 0) begin
            e.ena  = 1'b1;
            e.addr = bus.req_addr[5*g +: 5];
            e.data = bus.req_data[XLEN*g +: XLEN];
        end
        exp_q.push_back(e);
        if (m_pend_ena && m_pend_addr != 0) m_busy[m_pend_addr] = 1'b0;
        if (bus.iss_valid && exp_iss_ready && bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
        if (g >= 0) m_prio = (g + 1) % 3;
        m_pend_ena  = e.ena;
        m_pend_addr = int'(e.addr);
        last_grant  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rs1_addr  = '0;
        bus.rs2_addr  = '0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < 3; i++) begin
            if (!r_valid[i] && $urandom_range(0, 99) < 45) begin
                r_valid[i] = 1'b1;
                r_addr[i]  = 5'($urandom_range(0, 15));
                r_data[i]  = {$urandom, $urandom};
            end
            bus.req_valid[i]              = r_valid[i];
            bus.req_addr[5*i +: 5]        = r_addr[i];
            bus.req_data[XLEN*i +: XLEN]  = r_data[i];
        end
        bus.iss_valid = 1'($urandom_range(0, 1));
        bus.iss_rd    = 5'($urandom_range(0, 15));
        bus.rs1_addr  = 5'($urandom_range(0, 15));
        bus.rs2_addr  = 5'($urandom_range(0, 15));
    endtask

    // Entered just after a rising edge; asserts reset mid-cycle and leaves just after
    // the edge on which reset is released.
    task automatic do_reset();
        logic [2:0] rv;
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_w_ena",  64'(bus.w_ena),  64'd0);
        check("rst_w_addr", 64'(bus.w_addr), 64'd0);
        check("rst_w_data", bus.w_data,      64'd0);
        check("rst_busy",   64'(bus.busy_o), 64'd0);
        for (int i = 0; i < 3; i++) r_valid[i] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            drive_random();
            #1;
            rv = bus.req_valid;
            check("rst_hold_w_ena", 64'(bus.w_ena),     64'd0);
            check("rst_hold_busy",  64'(bus.busy_o),    64'd0);
            check("rst_iss_ready",  64'(bus.iss_ready), 64'd1);
            check("rst_rs1_busy",   64'(bus.rs1_busy),  64'd0);
            check("rst_req_ready",  64'(bus.req_ready), 64'(rv & (~rv + 3'd1)));
        end
        for (int i = 0; i < 3; i++) r_valid[i] = 1'b0;
        m_busy      = '0;
        m_prio      = 0;
        m_pend_ena  = 1'b0;
        m_pend_addr = 0;
        exp_q.delete();
        exp_q.push_back('0);
        set_idle();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        @(posedge clk);
        #1;
        do_reset();

        // Round robin with all three requesters held valid.
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {64'hC3, 64'hB2, 64'hA1};
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_grant", 64'(bus.req_ready), 64'(3'b001 << (i % 3)));
            if (i > 0) check("rr_waddr", 64'(bus.w_addr), 64'((i - 1) % 3 + 1));
            tick();
        end
        set_idle();
        #1;
        check("rr_waddr_last", 64'(bus.w_addr), 64'd3);
        tick();

        // RAW on x5: issue, wait, LSU write-back, observe release.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd5;
        bus.rs1_addr  = 5'd5;
        #1;
        check("raw_iss_ready", 64'(bus.iss_ready), 64'd1);
        tick();
        bus.iss_valid = 1'b0;
        #1;
        check("raw_busy_c1", 64'(bus.rs1_busy), 64'd1);
        tick();
        tick();
        bus.req_valid = 3'b010;
        bus.req_addr  = {5'd0, 5'd5, 5'd0};
        bus.req_data  = {64'h0, 64'hDEADBEEF, 64'h0};
        #1;
        check("raw_grant", 64'(bus.req_ready), 64'(3'b010));
        tick();
        set_idle();
        bus.rs1_addr = 5'd5;
        #1;
        check("raw_w_ena",  64'(bus.w_ena),    64'd1);
        check("raw_w_addr", 64'(bus.w_addr),   64'd5);
        check("raw_w_data", bus.w_data,        64'hDEADBEEF);
        check("raw_busy_c4", 64'(bus.rs1_busy), 64'd1);
        tick();
        #1;
        check("raw_busy_c5", 64'(bus.rs1_busy), 64'd0);
        tick();

        // WAW stall on x7.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        tick();
        #1;
        check("waw_stall_1", 64'(bus.iss_ready), 64'd0);
        tick();
        #1;
        check("waw_stall_2", 64'(bus.iss_ready), 64'd0);
        bus.req_valid = 3'b100;
        bus.req_addr  = {5'd7, 5'd0, 5'd0};
        bus.req_data  = {64'h7777, 64'h0, 64'h0};
        tick();
        bus.req_valid = 3'b000;
        #1;
        check("waw_w_ena",   64'(bus.w_ena),     64'd1);
        check("waw_stall_3", 64'(bus.iss_ready), 64'd0);
        tick();
        #1;
        check("waw_ready", 64'(bus.iss_ready), 64'd1);
        tick();
        bus.iss_valid = 1'b0;
        #1;
        check("waw_reset_busy", 64'(bus.busy_o[7]), 64'd1);
        tick();

        // Set/clear collision on x9: write to non-busy x9 commits as x9 is issued.
        set_idle();
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd9};
        bus.req_data  = {64'h0, 64'h0, 64'h9999};
        tick();
        bus.req_valid = 3'b000;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1;
        check("col_w_addr",    64'(bus.w_addr),    64'd9);
        check("col_iss_ready", 64'(bus.iss_ready), 64'd1);
        tick();
        bus.iss_valid = 1'b0;
        #1;
        check("col_busy9", 64'(bus.busy_o[9]), 64'd1);
        tick();

        // x0 handling: busy set is {7, 9} from here on.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        #1;
        check("x0_iss_ready", 64'(bus.iss_ready), 64'd1);
        tick();
        bus.iss_valid = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_addr  = '0;
        bus.req_data  = {64'h0, 64'h0, 64'h0BAD};
        #1;
        check("x0_busy_a", 64'(bus.busy_o),    64'h0000_0280);
        check("x0_grant",  64'(bus.req_ready), 64'(3'b001));
        tick();
        set_idle();
        #1;
        check("x0_w_ena",  64'(bus.w_ena),  64'd1);
        check("x0_w_addr", 64'(bus.w_addr), 64'd0);
        tick();
        #1;
        check("x0_busy_b", 64'(bus.busy_o), 64'h0000_0280);
        tick();

        // Random traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            drive_random();
            tick();
            if (last_grant >= 0) r_valid[last_grant] = 1'b0;
        end

        set_idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
